// File: rtl/tag_store.sv
// Tag/valid store with a two-stage lookup pipeline and an invalidate-all sweep.
// Optional write-to-lookup forwarding enabled by TAG_STORE_BYPASS_EN.
module tag_store #(
   parameter int ADDR_BITS = 6,
   parameter int TAG_BITS  = 3
) (
   input  logic                 clock_i,
   input  logic                 reset_ni,
   input  logic                 lookup_i,
   input  logic [ADDR_BITS-1:0] index_i,
   input  logic [TAG_BITS-1:0]  tag_i,
   input  logic                 wr_i,
   input  logic [ADDR_BITS-1:0] wr_index_i,
   input  logic [TAG_BITS-1:0]  wr_tag_i,
   input  logic                 flush_i,
   output logic                 busy_o,
   output logic                 ack_o,
   output logic                 hit_o,
   output logic                 valid_o,
   output logic [TAG_BITS-1:0]  tag_o
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic {FLUSH, IDLE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] cnt_q, cnt_d;
   logic                 wr_en;

   logic [TAG_BITS-1:0]  tag_mem [DEPTH];
   logic [DEPTH-1:0]     valid_mem;

   logic                 s1_v;
   logic [ADDR_BITS-1:0] s1_idx;
   logic [TAG_BITS-1:0]  s1_tag;

   logic                 rd_valid;
   logic [TAG_BITS-1:0]  rd_tag;
   logic                 rd_hit;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= FLUSH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_o  = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         FLUSH: begin
            busy_o = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (&cnt_q) state_d = IDLE;
         end
         IDLE: begin
            // a flush request drops any write issued alongside it
            if (flush_i) state_d = FLUSH;
            else         wr_en   = wr_i;
         end
         default: state_d = FLUSH;
      endcase
   end

   // sweep and writes never coincide, so one write port suffices
   always_ff @(posedge clock_i) begin
      if (busy_o) begin
         valid_mem[cnt_q] <= 1'b0;
      end else if (wr_en) begin
         valid_mem[wr_index_i] <= 1'b1;
         tag_mem[wr_index_i]   <= wr_tag_i;
      end
   end

   always_comb begin
      rd_valid = valid_mem[s1_idx];
      rd_tag   = tag_mem[s1_idx];
`ifdef TAG_STORE_BYPASS_EN
      if (wr_en && (wr_index_i == s1_idx)) begin
         rd_valid = 1'b1;
         rd_tag   = wr_tag_i;
      end
`endif
      rd_hit = rd_valid && (rd_tag == s1_tag);
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         s1_v    <= 1'b0;
         s1_idx  <= '0;
         s1_tag  <= '0;
         ack_o   <= 1'b0;
         hit_o   <= 1'b0;
         valid_o <= 1'b0;
         tag_o   <= '0;
      end else begin
         s1_v   <= lookup_i && !busy_o;
         s1_idx <= index_i;
         s1_tag <= tag_i;
         ack_o  <= s1_v;
         if (s1_v) begin
            hit_o   <= rd_hit;
            valid_o <= rd_valid;
            tag_o   <= rd_tag;
         end
      end
   end

endmodule

// File: tb/tb_tag_store.sv
// Randomized and directed bench for tag_store against a behavioural model.
module tb_tag_store;

   localparam int AB    = 6;
   localparam int TB    = 3;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          lookup = 1'b0;
   logic          wr = 1'b0;
   logic          flush = 1'b0;
   logic [AB-1:0] idx = '0;
   logic [AB-1:0] widx = '0;
   logic [TB-1:0] tg = '0;
   logic [TB-1:0] wtg = '0;
   logic          busy, ack, hit, valid;
   logic [TB-1:0] tag_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   tag_store #(.ADDR_BITS(AB), .TAG_BITS(TB)) dut (
      .clock_i(clk), .reset_ni(rst_n),
      .lookup_i(lookup), .index_i(idx), .tag_i(tg),
      .wr_i(wr), .wr_index_i(widx), .wr_tag_i(wtg),
      .flush_i(flush), .busy_o(busy), .ack_o(ack),
      .hit_o(hit), .valid_o(valid), .tag_o(tag_out)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // behavioural model: contents, remaining sweep cycles, pending lookup
   bit          mvalid [DEPTH];
   bit [TB-1:0] mtag   [DEPTH];
   bit          mknown [DEPTH];
   int          left = DEPTH;
   bit          p_v = 0;
   int          p_idx = 0;
   bit [TB-1:0] p_tag = 0;
   bit          e_ack = 0, e_valid = 0, e_hit = 0, e_known = 1;
   bit [TB-1:0] e_tag = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left = DEPTH; p_v = 0;
         e_ack = 0; e_valid = 0; e_hit = 0; e_tag = 0; e_known = 1;
      end else begin
         bit b, wc, rv;
         bit [TB-1:0] rt;
         b  = left > 0;
         wc = !b && wr && !flush;
         e_ack = p_v;
         if (p_v) begin
            rv = mvalid[p_idx];
            rt = mtag[p_idx];
            e_known = mknown[p_idx];
`ifdef TAG_STORE_BYPASS_EN
            if (wc && int'(widx) == p_idx) begin
               rv = 1; rt = wtg; e_known = 1;
            end
`endif
            e_valid = rv;
            e_tag   = rt;
            e_hit   = rv && (rt == p_tag);
         end
         if (wc) begin
            mvalid[widx] = 1; mtag[widx] = wtg; mknown[widx] = 1;
         end
         if (b) begin
            mvalid[DEPTH-left] = 0;
            left--;
         end else if (flush) begin
            left = DEPTH;
         end
         p_v   = lookup && !b;
         p_idx = int'(idx);
         p_tag = tg;
      end
   end

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      chk("busy", busy, 32'(left > 0));
      chk("ack", ack, 32'(e_ack));
      chk("valid", valid, 32'(e_valid));
      chk("hit", hit, 32'(e_hit));
      if (e_known) chk("tag", tag_out, 32'(e_tag));
   end

   typedef struct {
      int          c;
      logic [TB-1:0] t;
      logic        v;
      logic        h;
   } ack_t;
   ack_t acks[$];

   always @(negedge clk) begin
      if (ack) acks.push_back('{c: cyc, t: tag_out, v: valid, h: hit});
   end

   task automatic drive(bit lk, int i, int t, bit w, int wi, int wt, bit f);
      @(negedge clk);
      #1;
      lookup = lk; idx = AB'(i); tg = TB'(t);
      wr = w; widx = AB'(wi); wtg = TB'(wt); flush = f;
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("busy_timeout", busy, 0);
   endtask

   task automatic count_sweep(string name);
      int n = 1;
      #1 rst_n = 1'b1;
      while (n < 200) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk(name, n, 64);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_ack", ack, 0);
      chk("rst_tag", tag_out, 0);
      count_sweep("sweep_len");

      acks.delete();
      drive(1, 5, 3, 0, 0, 0, 0);
      idle(3);
      chk("l5_acks", acks.size(), 1);
      if (acks.size() == 1) begin
         chk("l5_valid", acks[0].v, 0);
         chk("l5_hit", acks[0].h, 0);
      end

      acks.delete();
      drive(0, 0, 0, 1, 10, 6, 0);
      drive(1, 10, 6, 0, 0, 0, 0);
      drive(1, 10, 2, 0, 0, 0, 0);
      idle(3);
      chk("w10_acks", acks.size(), 2);
      if (acks.size() == 2) begin
         chk("w10_hit", acks[0].h, 1);
         chk("w10_tag", acks[0].t, 6);
         chk("w10_miss", acks[1].h, 0);
         chk("w10_valid", acks[1].v, 1);
         chk("w10_tag2", acks[1].t, 6);
      end

      acks.delete();
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, i, i + 1, 0);
      for (int i = 0; i < 3; i++) drive(1, i, i + 1, 0, 0, 0, 0);
      idle(3);
      chk("b2b_acks", acks.size(), 3);
      if (acks.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("b2b_tag", acks[i].t, i + 1);
            chk("b2b_hit", acks[i].h, 1);
         end
         chk("b2b_gap1", acks[1].c - acks[0].c, 1);
         chk("b2b_gap2", acks[2].c - acks[1].c, 1);
      end

      acks.delete();
      drive(1, 20, 5, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 20, 5, 0);
      idle(2);
      drive(1, 20, 5, 0, 0, 0, 0);
      idle(3);
      chk("byp_acks", acks.size(), 2);
      if (acks.size() == 2) begin
`ifdef TAG_STORE_BYPASS_EN
         chk("byp_hit", acks[0].h, 1);
`else
         chk("byp_hit", acks[0].h, 0);
`endif
         chk("byp_later", acks[1].h, 1);
      end

      acks.delete();
      drive(0, 0, 0, 1, 7, 4, 1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (!busy) break;
         lookup = 1'b1;
         idx = AB'($urandom % DEPTH);
         tg = TB'($urandom);
         wr = 1'($urandom);
         widx = AB'($urandom);
         wtg = TB'($urandom);
         flush = 1'($urandom);
      end
      lookup = 0; wr = 0; flush = 0;
      wait_idle();
      chk("flush_acks", acks.size(), 0);
      acks.delete();
      drive(1, 7, 4, 0, 0, 0, 0);
      idle(3);
      chk("f7_acks", acks.size(), 1);
      if (acks.size() == 1) chk("f7_valid", acks[0].v, 0);

      drive(0, 0, 0, 1, 10, 6, 0);
      drive(1, 10, 6, 0, 0, 0, 0);
      idle(2);
      drive(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      repeat (29) @(negedge clk);
      chk("pre_rst_valid", valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_tag", tag_out, 0);
      chk("mid_rst_hit", hit, 0);
      repeat (2) @(negedge clk);
      count_sweep("resweep_len");

      for (int k = 0; k < 3000; k++) begin
         int i;
         i = int'($urandom % 16);
         drive(($urandom % 3) != 0, i,
               ($urandom % 2) ? int'(mtag[i]) : int'($urandom % 8),
               1'($urandom), int'($urandom % 16), int'($urandom % 8),
               ($urandom % 300) == 0);
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
